// File: rtl/core_inst_seq.sv
// core_inst_seq: instruction sequencer for one attention core.
//
// A single start pulse runs a complete job on the core's 30-bit instruction
// interface. The sequencer loads K and Q vectors into the current kmem/qmem
// bank, pushes K into the MAC array, streams Q through it, drains the array,
// and writes ofifo results into pmem. The kmem/qmem bank alternates between
// even and odd after every completed job.
//
// Optional feature macro: CORE_INST_SEQ_SFP_EN
//   defined   : an SFP/normalization pass into norm memory follows write-back.
//   undefined : write-back goes straight to DONE; the pmem_rd, norm and sfp
//               fields of inst are constant 0.
//
// Parameters
//   col       K vectors loaded into the array (kmem addresses 0..col-1), <= 16
//   n_q       Q vectors per job (qmem/pmem/norm addresses 0..n_q-1), 1..16
//   drain_cyc idle cycles after the last mac_exe, < 256
//   fifo_lat  cycles from ofifo_rd to the matching pmem_wr
//
// Ports
//   clk       single clock
//   reset     synchronous, active-high
//   start     job request, sampled only while idle
//   in_valid  external load data valid this cycle
//   in_ready  high during the K and Q load phases
//   inst      core instruction word
//   busy      high whenever a job is in progress
//   done      one-cycle pulse at job end
//   bank      current kmem/qmem bank (0 = even, 1 = odd)
//
// Timing: every output is a flop. busy, in_ready, done and bank line up with
// the FSM state. inst is computed from the current state, phase counter and
// in_valid, so each instruction word appears in the cycle after the state
// cycle that issued it; a load beat accepted in cycle c drives its write
// word in cycle c+1.
module core_inst_seq #(
  parameter int unsigned col       = 8,
  parameter int unsigned n_q       = 8,
  parameter int unsigned drain_cyc = 16,
  parameter int unsigned fifo_lat  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [29:0] inst,
  output logic        busy,
  output logic        done,
  output logic        bank
);

  // Phase counter width; wide enough for the longest phase (drain_cyc).
  localparam int unsigned CntW = 8;

  // inst bit positions.
  localparam int unsigned PmemWr   = 0;
  localparam int unsigned KmemWrE  = 2;
  localparam int unsigned KmemWrO  = 3;
  localparam int unsigned KmemRdE  = 4;
  localparam int unsigned KmemRdO  = 5;
  localparam int unsigned QmemWrE  = 6;
  localparam int unsigned QmemWrO  = 7;
  localparam int unsigned QmemRdE  = 8;
  localparam int unsigned QmemRdO  = 9;
  localparam int unsigned OfifoRd  = 18;
  localparam int unsigned MacLoadk = 19;
  localparam int unsigned MacExe   = 20;
`ifdef CORE_INST_SEQ_SFP_EN
  localparam int unsigned PmemRd     = 1;
  localparam int unsigned NormWr     = 21;
  localparam int unsigned SfpAcc     = 27;
  localparam int unsigned SfpDiv     = 28;
  localparam int unsigned SfpIfifoWr = 29;
`endif

  // Phase boundaries in counter units.
  localparam logic [CntW-1:0] One       = CntW'(1);
  localparam logic [CntW-1:0] ColC      = CntW'(col);
  localparam logic [CntW-1:0] ColLast   = CntW'(col - 1);
  localparam logic [CntW-1:0] NqC       = CntW'(n_q);
  localparam logic [CntW-1:0] NqLast    = CntW'(n_q - 1);
  localparam logic [CntW-1:0] DrainLast = CntW'(drain_cyc - 1);
  localparam logic [CntW-1:0] LatC      = CntW'(fifo_lat);
  localparam logic [CntW-1:0] WbLast    = CntW'(n_q + fifo_lat - 1);
`ifdef CORE_INST_SEQ_SFP_EN
  localparam logic [CntW-1:0] Two       = CntW'(2);
  localparam logic [CntW-1:0] Three     = CntW'(3);
  localparam logic [CntW-1:0] Four      = CntW'(4);
  localparam logic [CntW-1:0] NqP1      = CntW'(n_q + 1);
  localparam logic [CntW-1:0] NqP2      = CntW'(n_q + 2);
  localparam logic [CntW-1:0] SfpLast   = CntW'(n_q + 3);
`endif

  typedef enum logic [3:0] {
    StIdle,
    StKload,
    StQload,
    StKread,
    StExec,
    StDrain,
    StWb,
    StSfp,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bank_d;
  logic            busy_d, in_ready_d, done_d;
  logic [29:0]     inst_d;
  logic            hs;

  // Load handshake; in_ready is only ever high in the two load states.
  assign hs = in_valid && in_ready;

  // Next-state and phase counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bank_d  = bank;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (col == 0) ? StQload : StKload;
          cnt_d   = '0;
        end
      end
      StKload: begin
        if (hs) begin
          if (cnt_q == ColLast) begin
            state_d = StQload;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + One;
          end
        end
      end
      StQload: begin
        if (hs) begin
          if (cnt_q == NqLast) begin
            state_d = StKread;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + One;
          end
        end
      end
      StKread: begin
        // col reads plus one trailing cycle for the delayed mac_loadk.
        if (cnt_q == ColC) begin
          state_d = StExec;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + One;
        end
      end
      StExec: begin
        // n_q reads plus one trailing cycle for the delayed mac_exe.
        if (cnt_q == NqC) begin
          state_d = (drain_cyc == 0) ? StWb : StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + One;
        end
      end
      StDrain: begin
        if (cnt_q == DrainLast) begin
          state_d = StWb;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + One;
        end
      end
      StWb: begin
        if (cnt_q == WbLast) begin
`ifdef CORE_INST_SEQ_SFP_EN
          state_d = StSfp;
`else
          state_d = StDone;
`endif
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + One;
        end
      end
`ifdef CORE_INST_SEQ_SFP_EN
      StSfp: begin
        if (cnt_q == SfpLast) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + One;
        end
      end
`endif
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
        bank_d  = ~bank;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State-aligned status outputs, registered from the next state.
  always_comb begin
    busy_d     = (state_d != StIdle);
    in_ready_d = (state_d == StKload) || (state_d == StQload);
    done_d     = (state_d == StDone);
  end

  // Instruction word for the current state cycle; delayed fields are ORed
  // in from the same phase counter so overlapping pulses share one word.
  always_comb begin
    inst_d = '0;
    case (state_q)
      StKload: begin
        if (hs) begin
          inst_d[KmemWrE] = ~bank;
          inst_d[KmemWrO] = bank;
          inst_d[17:14]   = cnt_q[3:0];
        end
      end
      StQload: begin
        if (hs) begin
          inst_d[QmemWrE] = ~bank;
          inst_d[QmemWrO] = bank;
          inst_d[17:14]   = cnt_q[3:0];
        end
      end
      StKread: begin
        if (cnt_q < ColC) begin
          inst_d[KmemRdE] = ~bank;
          inst_d[KmemRdO] = bank;
          inst_d[17:14]   = cnt_q[3:0];
        end
        if (cnt_q >= One) begin
          inst_d[MacLoadk] = 1'b1;
        end
      end
      StExec: begin
        if (cnt_q < NqC) begin
          inst_d[QmemRdE] = ~bank;
          inst_d[QmemRdO] = bank;
          inst_d[17:14]   = cnt_q[3:0];
        end
        if (cnt_q >= One) begin
          inst_d[MacExe] = 1'b1;
        end
      end
      StWb: begin
        if (cnt_q < NqC) begin
          inst_d[OfifoRd] = 1'b1;
        end
        // pmem_wr k follows ofifo_rd k by fifo_lat cycles.
        if (cnt_q >= LatC) begin
          inst_d[PmemWr] = 1'b1;
          inst_d[13:10]  = cnt_q[3:0] - LatC[3:0];
        end
      end
`ifdef CORE_INST_SEQ_SFP_EN
      StSfp: begin
        // Five-stage pipeline per vector k: pmem_rd at k, ififo write at k+1,
        // accumulate at k+2, divide at k+3, norm write at k+4.
        if (cnt_q < NqC) begin
          inst_d[PmemRd] = 1'b1;
          inst_d[13:10]  = cnt_q[3:0];
        end
        if ((cnt_q >= One) && (cnt_q <= NqC)) begin
          inst_d[SfpIfifoWr] = 1'b1;
        end
        if ((cnt_q >= Two) && (cnt_q <= NqP1)) begin
          inst_d[SfpAcc] = 1'b1;
        end
        if ((cnt_q >= Three) && (cnt_q <= NqP2)) begin
          inst_d[SfpDiv] = 1'b1;
        end
        if (cnt_q >= Four) begin
          inst_d[NormWr] = 1'b1;
          inst_d[26:23]  = cnt_q[3:0] - Four[3:0];
        end
      end
`endif
      default: begin
        inst_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bank     <= 1'b0;
      busy     <= 1'b0;
      in_ready <= 1'b0;
      done     <= 1'b0;
      inst     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bank     <= bank_d;
      busy     <= busy_d;
      in_ready <= in_ready_d;
      done     <= done_d;
      inst     <= inst_d;
    end
  end

endmodule

// File: tb/tb_core_inst_seq.sv
// Directed testbench for core_inst_seq (default parameters). Outputs are
// observed 1 ns after each rising edge; cycle n of a job is the n-th cycle
// after the edge that samples start.
module tb_core_inst_seq;

`ifdef CORE_INST_SEQ_SFP_EN
  localparam int JobLen = 72;
`else
  localparam int JobLen = 60;
`endif
  localparam int Throttle = 15;  // extra cycles when in_valid toggles

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] inst;
  logic        busy;
  logic        done;
  logic        bank;

  always #5 clk = ~clk;

  core_inst_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .inst     (inst),
    .busy     (busy),
    .done     (done),
    .bank     (bank)
  );

`ifdef CORE_INST_SEQ_SFP_EN
  logic        in_ready2;
  logic [29:0] inst2;
  logic        busy2;
  logic        done2;
  logic        bank2;
  logic [29:0] log_inst2 [0:255];
  logic        log_done2 [0:255];

  core_inst_seq #(
    .n_q (2)
  ) dut2 (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (1'b1),
    .in_ready (in_ready2),
    .inst     (inst2),
    .busy     (busy2),
    .done     (done2),
    .bank     (bank2)
  );
`endif

  int n_checks = 0;
  int n_err    = 0;

  logic [29:0] log_inst  [0:255];
  logic        log_ready [0:255];
  logic        log_valid [0:255];
  logic        log_bank  [0:255];
  logic        log_busy  [0:255];
  logic        log_done  [0:255];
  int          done_at;
  int          done_cnt;

  // scan results
  int          kwr_cnt, kwr_bad, qwr_cnt, loadk_cnt, exe_cnt, ofifo_cnt, pwr_cnt;
  int          ready_cnt, zero_bad, bank1_cnt, last_kwr, busy_cnt;
  logic [29:0] or_all;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one job from a start pulse, logging outputs per cycle. extra_start_n
  // pulses start again in that cycle; reset_n aborts with a 3-cycle reset.
  task automatic run_job(input bit throttle, input int extra_start_n, input int reset_n,
                         input int tail);
    int n;
    done_at  = -1;
    done_cnt = 0;
    start    = 1'b1;
    in_valid = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (n < 250) begin
      log_inst[n]  = inst;
      log_ready[n] = in_ready;
      log_bank[n]  = bank;
      log_busy[n]  = busy;
      log_done[n]  = done;
`ifdef CORE_INST_SEQ_SFP_EN
      log_inst2[n] = inst2;
      log_done2[n] = done2;
`endif
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (done_at > 0 && n >= done_at + tail) break;
      if (n == reset_n) begin
        reset = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b0;
        break;
      end
      in_valid     = throttle ? n[0] : 1'b1;
      log_valid[n] = in_valid;
      start        = (n == extra_start_n);
      tick();
      n++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic scan(input int lo, input int hi);
    logic [29:0] w;
    kwr_cnt = 0; kwr_bad = 0; qwr_cnt = 0; loadk_cnt = 0; exe_cnt = 0;
    ofifo_cnt = 0; pwr_cnt = 0; ready_cnt = 0; zero_bad = 0; bank1_cnt = 0;
    last_kwr = 0; busy_cnt = 0; or_all = '0;
    for (int n = lo; n <= hi; n++) begin
      w = log_inst[n];
      or_all |= w;
      if (w[2]) begin
        if (w[17:14] != 4'(kwr_cnt)) kwr_bad++;
        kwr_cnt++;
        last_kwr = n;
      end
      if (w[6])  qwr_cnt++;
      if (w[19]) loadk_cnt++;
      if (w[20]) exe_cnt++;
      if (w[18]) ofifo_cnt++;
      if (w[0])  pwr_cnt++;
      if (log_ready[n]) ready_cnt++;
      if (log_bank[n])  bank1_cnt++;
      if (log_busy[n])  busy_cnt++;
      if (n > lo && log_ready[n-1] && !log_valid[n-1] && w != 0) zero_bad++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("rst_inst", inst, 0);
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bank", bank, 0);
    reset = 1'b0;
    tick();

    // Job A: default, bank 0, in_valid held high.
    run_job(1'b0, -1, -1, 1);
    check("a_done_at", done_at, JobLen);
    check("a_done_cnt", done_cnt, 1);
    check("a_busy_rise", log_busy[1], 1);
    check("a_ready_rise", log_ready[1], 1);
    check("a_ready_last", log_ready[16], 1);
    check("a_ready_drop", log_ready[17], 0);
    check("a_word1", log_inst[1], 0);
    check("a_kwr0", log_inst[2], 32'h4);
    check("a_kwr7", log_inst[9], 32'h1c004);
    check("a_qwr0", log_inst[10], 32'h40);
    check("a_kread0", log_inst[18], 32'h10);
    check("a_kread1", log_inst[19], 32'h84010);
    check("a_wb1", log_inst[53], 32'h40001);
    check("a_wblast", log_inst[60], 32'h1c01);
    scan(1, done_at);
    check("a_kwr_cnt", kwr_cnt, 8);
    check("a_kwr_addr", kwr_bad, 0);
    check("a_qwr_cnt", qwr_cnt, 8);
    check("a_loadk_cnt", loadk_cnt, 8);
    check("a_exe_cnt", exe_cnt, 8);
    check("a_ofifo_cnt", ofifo_cnt, 8);
    check("a_pwr_cnt", pwr_cnt, 8);
    check("a_odd_bits", or_all & 30'h2a8, 0);
`ifdef CORE_INST_SEQ_SFP_EN
    check("s_pmem_rd0", log_inst2[43], 32'h2);
    check("s_pmem_rd1", log_inst2[44], 32'h20000402);
    check("s_acc", log_inst2[45], 32'h28000000);
    check("s_acc_div", log_inst2[46], 32'h18000000);
    check("s_norm0", log_inst2[47], 32'h10200000);
    check("s_norm1", log_inst2[48], 32'ha00000);
    check("s_done", log_done2[48], 1);
`else
    check("a_sfp_bits", or_all & 30'h3fe00002, 0);
`endif
    check("a_bank_after", log_bank[done_at + 1], 1);

    // Job B: back-to-back, odd bank.
    run_job(1'b0, -1, -1, 1);
    check("b_done_at", done_at, JobLen);
    scan(1, done_at);
    check("b_bank_during", bank1_cnt, JobLen);
    check("b_even_bits", or_all & 30'h154, 0);
    check("b_odd_bits", or_all & 30'h2a8, 30'h2a8);
    check("b_bank_after", log_bank[done_at + 1], 0);

    // Job C: throttled load, bank 0.
    run_job(1'b1, -1, -1, 1);
    check("c_done_at", done_at, JobLen + Throttle);
    scan(1, done_at);
    check("c_kwr_cnt", kwr_cnt, 8);
    check("c_kwr_addr", kwr_bad, 0);
    check("c_kload_end", last_kwr, 16);
    check("c_idle_zero", zero_bad, 0);
    check("c_ready_cnt", ready_cnt, 31);
    check("c_qwr_cnt", qwr_cnt, 8);

    // Job E: bank 1, reset mid-EXEC.
    run_job(1'b0, -1, 28, 1);
    check("e_inst", inst, 0);
    check("e_busy", busy, 0);
    check("e_bank", bank, 0);
    check("e_ready", in_ready, 0);

    // Job F: full job after reset, bank 0.
    run_job(1'b0, -1, -1, 1);
    check("f_done_at", done_at, JobLen);
    scan(1, done_at);
    check("f_odd_bits", or_all & 30'h2a8, 0);

    // Job D: start pulsed during DRAIN is ignored.
    run_job(1'b0, 40, -1, 12);
    check("d_done_at", done_at, JobLen);
    check("d_done_cnt", done_cnt, 1);
    scan(done_at + 1, done_at + 12);
    check("d_idle_busy", busy_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/core_inst_seq.md
# core_inst_seq

Instruction sequencer that drives the 30-bit `inst` word of one attention core, acting as the initiator side of the core's instruction interface. One `start` pulse runs a complete job. It loads K and Q vectors into the selected kmem/qmem bank, pushes K into the MAC array, streams Q through it, drains the array, and writes results from the output FIFO into pmem. When compiled in, it also runs the SFP/normalization pass into norm memory. The kmem/qmem bank alternates even/odd on each completed job.

## Interface
- `col`, default 8: K vectors loaded into the array (kmem addresses 0..col-1); must be ≤16.
- `n_q`, default 8: Q vectors per job (qmem/pmem/norm addresses 0..n_q-1); must be 1..16.
- `drain_cyc`, default 16: idle cycles after the last `mac_exe`, allowing array results to reach the ofifo.
- `fifo_lat`, default 1: cycles from `ofifo_rd` until the matching `pmem_wr`.
- `clk` input 1: the single clock.
- `reset` input 1: synchronous, active-high.
- `start` input 1: job request; sampled only in IDLE.
- `in_valid` input 1: external data on `mem_in` is valid this cycle (load phases).
- `in_ready` output 1: high in KLOAD/QLOAD; a write issues when `in_valid && in_ready`.
- `inst` output 30: core instruction word.
- `busy` output 1: high whenever state ≠ IDLE.
- `done` output 1: one-cycle pulse at job end.
- `bank` output 1: current bank; 0 = even, 1 = odd.

## Operation
- `inst` field map:
  - [0] `pmem_wr`, [1] `pmem_rd`.
  - [2]/[3] `kmem_wr` even/odd, [4]/[5] `kmem_rd` even/odd.
  - [6]/[7] `qmem_wr` even/odd, [8]/[9] `qmem_rd` even/odd.
  - [13:10] `pmem_add`, [17:14] `qkmem_add`.
  - [18] `ofifo_rd`, [19] `mac_loadk`, [20] `mac_exe`.
  - [21] `norm_wr`, [22] `norm_rd`, [26:23] `norm_add`.
  - [28:27] `sfp_inst`, [29] `sfp_ififo_wr`.
- Bank select: with `bank`=0 only the even bits of each kmem/qmem pair are driven; with `bank`=1 only the odd bits. Unused fields are 0.
- FSM states: IDLE → KLOAD → QLOAD → KREAD → EXEC → DRAIN → WB → [SFP] → DONE → IDLE.
- IDLE: `inst`=0. `start`=1 → KLOAD with counter cleared.
- KLOAD: on each handshake, `kmem_wr`=1 and `qkmem_add`=cnt, then cnt++. No handshake → `inst`=0 and cnt holds. After col beats → QLOAD.
- QLOAD: same scheme with `qmem_wr`, n_q beats → KREAD.
- KREAD: `kmem_rd` with addr 0..col-1 on consecutive cycles. `mac_loadk` is asserted one cycle after each read, for col cycles. Phase length col+1 → EXEC.
- EXEC: `qmem_rd` with addr 0..n_q-1. `mac_exe` follows one cycle later, for n_q cycles. Phase length n_q+1 → DRAIN.
- DRAIN: `inst`=0 for drain_cyc cycles → WB.
- WB: `ofifo_rd` for n_q cycles. `pmem_wr` with `pmem_add` k lags `ofifo_rd` number k by fifo_lat cycles. Phase length n_q+fifo_lat → SFP or DONE.
- DONE: `done`=1 for one cycle, `bank` toggles, → IDLE.
- Overlapping delayed fields share one `inst` word; fields are ORed per bit and never conflict.
- `start` while busy: ignored, not queued.
- Reset at any point: next cycle state is IDLE and all counters are 0.

## Timing
- Reset values: `inst`=0, `in_ready`=0, `busy`=0, `done`=0, `bank`=0.
- All outputs are registered.
- `start` sampled at edge t → `busy` and `in_ready` high from t+1.
- Job length in cycles: col + n_q (if `in_valid` is held high) + (col+1) + (n_q+1) + drain_cyc + (n_q+fifo_lat) + [n_q+4] + 1.
- Defaults without SFP: 8+8+9+9+16+9+1 = 60 cycles. With SFP: 72 cycles.
- `in_ready` drops in the cycle after the last accepted QLOAD beat.

## Configuration
- `CORE_INST_SEQ_SFP_EN` defined: the SFP state is present after WB.
  - `pmem_rd` with address k is issued at cycle k, k = 0..n_q-1.
  - `sfp_ififo_wr` at k+1.
  - `sfp_inst`=2'b01 (accumulate) at k+2.
  - `sfp_inst`=2'b10 (divide) at k+3.
  - `norm_wr` with `norm_add`=k at k+4.
  - Phase length n_q+4.
- Not defined: WB → DONE directly. Bits [1], [21], [22], [26:23], [28:27] and [29] are constant 0.

## Test plan
- Reset check: reset held 3 cycles mid-EXEC → next cycle `inst`=0, `busy`=0, `bank`=0; a new `start` then runs a complete 60-cycle job.
- Default job, `in_valid`=1 throughout:
  - `start` → `done` pulse exactly 60 cycles later (72 with macro).
  - First KREAD cycle: `inst` = 0x00000010 (kmem_rd even, addr 0).
  - Next cycle: bits [19] and [4] both set, with addr 1.
- Throttled load: `in_valid` toggles 1,0,1,0… → 8 kmem writes at addrs 0..7, issued only on valid cycles; `inst`=0 on invalid cycles; KLOAD lasts 15 cycles.
- Ping-pong: two back-to-back jobs → the second uses bits [3], [5], [7], [9] only, `bank`=1 during it, and `bank` returns to 0 after its `done`.
- Busy start: `start` pulsed during DRAIN → ignored; exactly one `done` pulse.
- With macro, n_q=2: SFP phase emits `pmem_rd` at addrs 0,1 and `norm_wr` at addrs 0,1 on its cycles 4 and 5; `sfp_inst`=01 on cycles 2–3 and 10 on cycles 3–4, ORed to 11 on cycle 3.
